sipo_frame_ctrl: RTL and testbench
==================================

# sipo_frame_ctrl

Frame controller that sequences a serial-in/parallel-out shift register. It gates bit strobes into the shifter and counts WIDTH bits per frame. It then moves the completed word into an output holding register that a downstream consumer drains with a valid/ready handshake. It sits between a serial bit source (strobed, with a frame-start pulse) and any parallel-word consumer, and flags dropped data.

## Interface
- WIDTH, 4: bits per frame / parallel word width; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame-start pulse.
- abort  input  1  discard the partial frame.
- si  input  1  serial data bit.
- si_valid  input  1  si is valid this cycle.
- po  output  WIDTH  parallel word (holding register).
- po_valid  output  1  po holds an unconsumed word.
- po_ready  input  1  consumer accepts po this cycle.
- busy  output  1  controller not in IDLE.
- bit_cnt  output  $clog2(WIDTH+1)  bits accepted in the current frame.
- overrun  output  1  sticky: data or start dropped.
- clr_ovr  input  1  clears overrun.

## Operation
- Shift rule: each accepted bit does shreg <= {shreg[WIDTH-2:0], si}. The first bit of a frame ends at po[WIDTH-1]; the last bit ends at po[0].
- States: IDLE, SHIFT, LOAD.
- IDLE:
  - si_valid is ignored (no flag).
  - start → SHIFT, with bit_cnt <= 0 and shreg <= 0.
  - si_valid in the start cycle is not accepted.
- SHIFT, evaluated in priority order:
  - abort → IDLE, bit_cnt <= 0, partial frame discarded, no flag.
  - start → restart: stay in SHIFT, bit_cnt <= 0, shreg <= 0. A simultaneous si_valid bit is discarded.
  - si_valid → shift in si and increment bit_cnt. When this is the WIDTH-th bit, go to LOAD.
- LOAD:
  - If !po_valid || po_ready: po <= shreg, po_valid <= 1, bit_cnt <= 0, go to IDLE.
  - Otherwise stay in LOAD; shreg is held.
  - Any si_valid or start in LOAD is dropped and sets overrun.
  - abort in LOAD → IDLE, word discarded, no flag.
- Output handshake: a word transfers on a cycle with po_valid && po_ready.
  - po_valid clears after the transfer unless LOAD reloads in that same cycle, in which case it stays 1 with the new word.
  - po is stable while po_valid=1 and po_ready=0.
- overrun: set by any drop in LOAD. It stays set until clr_ovr or rst. If a set event and clr_ovr occur in the same cycle, set wins.
- busy = (state != IDLE).

## Timing
- All outputs are registered. Reset values: state IDLE, po=0, po_valid=0, bit_cnt=0, overrun=0, busy=0, shreg=0.
- rst overrides every other input. A frame in progress or an unconsumed word is discarded.
- Latency:
  - start sampled at edge E: busy=1 after E. The first bit is acceptable at edge E+1.
  - WIDTH-th bit sampled at edge N: LOAD after N.
  - If the output slot is free, po/po_valid update at edge N+1, and busy=0 after N+1.
- Minimum frame period is WIDTH+2 cycles (start cycle, WIDTH bit cycles, LOAD cycle). A start in the LOAD cycle is an overrun, so back-to-back frames need start no earlier than the cycle after LOAD.
- A consumer holding po_ready=1 continuously yields one word per frame with no stall.
- bit_cnt never exceeds WIDTH. It reads WIDTH only while in LOAD.

## Test plan
- Basic frame, WIDTH=4:
  - Stimulus: start, then bits 1,0,1,1 on consecutive si_valid cycles, po_ready=1.
  - Response: po=4'b1011 and po_valid=1 for exactly one cycle, at edge N+1 after the 4th bit. busy returns to 0. overrun=0.
- Gapped strobes:
  - Stimulus: the same frame with si_valid low for 3 cycles between bits, plus si toggling while si_valid=0.
  - Response: po=4'b1011. bit_cnt steps 0,1,2,3,4 only on strobe cycles.
- Backpressure:
  - Stimulus: po_ready=0, frame A=4'b1100 then frame B=4'b0011.
  - Response: A is held stable. B completes and waits in LOAD with busy=1. A bit strobed during that wait sets overrun.
  - When po_ready=1 for one cycle, A transfers and B loads the same cycle (po_valid stays 1, po=4'b0011).
- Restart and abort:
  - Stimulus: start, bits 1,1, start again, then bits 0,1,0,1.
  - Response: po=4'b0101.
  - Stimulus: separately, start, bits 1,0, abort.
  - Response: IDLE, bit_cnt=0, no po_valid, no overrun.
- Reset mid-operation:
  - Stimulus: rst asserted after 2 bits of a frame, and separately while po_valid=1 with po_ready=0.
  - Response: the next edge gives po=0, po_valid=0, bit_cnt=0, busy=0, overrun=0.
- Overrun clear:
  - Stimulus: create an overrun, then assert clr_ovr.
  - Response: overrun=0 after the next edge.
  - Stimulus: clr_ovr in the same cycle as a drop.
  - Response: overrun remains 1.

Source files
------------

// File: rtl/sipo_frame_ctrl_if.sv
// Bus bundle for sipo_frame_ctrl: serial bit source, parallel word consumer
// and the status/control lines. The master side drives the serial source and
// consumer controls; the slave side is the frame controller.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic             abort;
    logic             si;
    logic             si_valid;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             po_ready;
    logic             busy;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
    logic             clr_ovr;

    modport master (
        output start, abort, si, si_valid, po_ready, clr_ovr,
        input  po, po_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  start, abort, si, si_valid, po_ready, clr_ovr,
        output po, po_valid, busy, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller. Accepts WIDTH strobed bits per
// frame (MSB first), parks the finished word in LOAD until the single-entry
// output holding register is free, and flags anything dropped while parked.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_frame_ctrl_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic             po_valid_q, po_valid_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    // Next-state computation for the frame FSM, holding register and overrun flag.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        po_d       = po_q;
        po_valid_d = po_valid_q;
        bit_cnt_d  = bit_cnt_q;
        overrun_d  = overrun_q;

        // A consumed word frees the slot; a reload below may refill it this cycle.
        if (po_valid_q && bus.po_ready) begin
            po_valid_d = 1'b0;
        end

        if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (bus.start) begin
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end else if (bus.si_valid) begin
                    shreg_d   = {shreg_q[WIDTH-2:0], bus.si};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // Set beats clear when both land in one cycle.
                if (bus.si_valid || bus.start) begin
                    overrun_d = 1'b1;
                end
                if (bus.abort) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (!po_valid_q || bus.po_ready) begin
                    po_d       = shreg_q;
                    po_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Register all state; synchronous reset discards any frame or parked word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            bit_cnt_q  <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
            bit_cnt_q  <= bit_cnt_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.po       = po_q;
    assign bus.po_valid = po_valid_q;
    assign bus.bit_cnt  = bit_cnt_q;
    assign bus.overrun  = overrun_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=4): a vector table of per-cycle
// inputs and post-edge expected outputs, plus a back-to-back frame sequence.
module tb_sipo_frame_ctrl;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;

    sipo_frame_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, abort, si, siv, rdy, clr;
        logic [3:0] e_po;
        logic       e_pv, e_busy;
        logic [2:0] e_cnt;
        logic       e_ovr;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] words[$];
    logic       mon;
    int         checks;
    int         errors;

    task automatic add(input logic r, st, ab, s, sv, rd, cl,
                       input logic [3:0] po, input logic pv, bz,
                       input logic [2:0] cnt, input logic ov);
        vec_t v;
        v.rst = r; v.start = st; v.abort = ab; v.si = s; v.siv = sv;
        v.rdy = rd; v.clr = cl;
        v.e_po = po; v.e_pv = pv; v.e_busy = bz; v.e_cnt = cnt; v.e_ovr = ov;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, st, ab, s, sv, rd, cl);
        rst = r; bus.start = st; bus.abort = ab; bus.si = s;
        bus.si_valid = sv; bus.po_ready = rd; bus.clr_ovr = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon && bus.po_valid) words.push_back(bus.po);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec%0d got %0h exp %0h", name, idx, got, exp);
        end
    endtask

    task automatic frame(input logic [3:0] w);
        drive(0, 1, 0, 0, 0, 1, 0); tick();
        for (int b = 3; b >= 0; b--) begin
            drive(0, 0, 0, w[b], 1, 1, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0); tick();   // LOAD cycle
    endtask

    initial begin
        logic [3:0] exp_w[3];
        checks = 0;
        errors = 0;
        mon    = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);

        //   rst st ab si sv rd cl    po  pv bz cnt ov
        add(1, 0, 0, 0, 0, 0, 0,   4'h0, 0, 0, 0, 0);   // reset
        // basic frame 1011
        add(0, 1, 0, 0, 0, 1, 0,   4'h0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0,   4'h0, 0, 1, 2, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h0, 0, 1, 3, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h0, 0, 1, 4, 0);   // LOAD
        add(0, 0, 0, 0, 0, 1, 0,   4'hB, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'hB, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'hB, 0, 0, 0, 0);   // IDLE ignores si_valid
        // gapped strobes 1011, si toggling while si_valid low
        add(0, 1, 0, 1, 1, 1, 0,   4'hB, 0, 1, 0, 0);   // si_valid with start not taken
        add(0, 0, 0, 1, 1, 1, 0,   4'hB, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'hB, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0,   4'hB, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'hB, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0,   4'hB, 0, 1, 2, 0);
        add(0, 0, 0, 1, 0, 1, 0,   4'hB, 0, 1, 2, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'hB, 0, 1, 2, 0);
        add(0, 0, 0, 1, 0, 1, 0,   4'hB, 0, 1, 2, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'hB, 0, 1, 3, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'hB, 0, 1, 3, 0);
        add(0, 0, 0, 1, 0, 1, 0,   4'hB, 0, 1, 3, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'hB, 0, 1, 3, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'hB, 0, 1, 4, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'hB, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'hB, 0, 0, 0, 0);
        // backpressure: A=1100 then B=0011 with po_ready low
        add(0, 1, 0, 0, 0, 0, 0,   4'hB, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'hB, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'hB, 0, 1, 2, 0);
        add(0, 0, 0, 0, 1, 0, 0,   4'hB, 0, 1, 3, 0);
        add(0, 0, 0, 0, 1, 0, 0,   4'hB, 0, 1, 4, 0);
        add(0, 0, 0, 0, 0, 0, 0,   4'hC, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   4'hC, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,   4'hC, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0,   4'hC, 1, 1, 2, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'hC, 1, 1, 3, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'hC, 1, 1, 4, 0);   // LOAD, slot full
        add(0, 0, 0, 0, 0, 0, 0,   4'hC, 1, 1, 4, 0);
        add(0, 0, 0, 0, 0, 0, 0,   4'hC, 1, 1, 4, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'hC, 1, 1, 4, 1);   // drop sets overrun
        add(0, 0, 0, 0, 0, 1, 0,   4'h3, 1, 0, 0, 1);   // A out, B in same cycle
        add(0, 0, 0, 0, 0, 0, 0,   4'h3, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1,   4'h3, 1, 0, 0, 0);   // clr_ovr
        add(0, 0, 0, 0, 0, 1, 0,   4'h3, 0, 0, 0, 0);
        // drop (start in LOAD) with clr_ovr in the same cycle: set wins
        add(0, 1, 0, 0, 0, 1, 0,   4'h3, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h3, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0,   4'h3, 0, 1, 2, 0);
        add(0, 0, 0, 0, 1, 1, 0,   4'h3, 0, 1, 3, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h3, 0, 1, 4, 0);
        add(0, 1, 0, 0, 0, 1, 1,   4'h9, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1,   4'h9, 0, 0, 0, 0);
        // restart: 1,1, start, 0,1,0,1
        add(0, 1, 0, 0, 0, 1, 0,   4'h9, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h9, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h9, 0, 1, 2, 0);
        add(0, 1, 0, 1, 1, 1, 0,   4'h9, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0,   4'h9, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h9, 0, 1, 2, 0);
        add(0, 0, 0, 0, 1, 1, 0,   4'h9, 0, 1, 3, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h9, 0, 1, 4, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'h5, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'h5, 0, 0, 0, 0);
        // abort mid-frame
        add(0, 1, 0, 0, 0, 1, 0,   4'h5, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h5, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0,   4'h5, 0, 1, 2, 0);
        add(0, 0, 1, 0, 0, 1, 0,   4'h5, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   4'h5, 0, 0, 0, 0);
        // reset after two bits
        add(0, 1, 0, 0, 0, 1, 0,   4'h5, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h5, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0,   4'h5, 0, 1, 2, 0);
        add(1, 0, 0, 1, 1, 1, 0,   4'h0, 0, 0, 0, 0);
        // parked word 1111, then abort in LOAD, then reset with po_valid held
        add(0, 1, 0, 0, 0, 0, 0,   4'h0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'h0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'h0, 0, 1, 2, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'h0, 0, 1, 3, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'h0, 0, 1, 4, 0);
        add(0, 0, 0, 0, 0, 0, 0,   4'hF, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   4'hF, 1, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'hF, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0,   4'hF, 1, 1, 2, 0);
        add(0, 0, 0, 1, 1, 0, 0,   4'hF, 1, 1, 3, 0);
        add(0, 0, 0, 0, 1, 0, 0,   4'hF, 1, 1, 4, 0);
        add(0, 0, 1, 0, 0, 0, 0,   4'hF, 1, 0, 0, 0);   // abort in LOAD
        add(0, 0, 0, 0, 0, 0, 0,   4'hF, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,   4'h0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].si,
                  vecs[i].siv, vecs[i].rdy, vecs[i].clr);
            tick();
            chk("po",       i, 32'(bus.po),       32'(vecs[i].e_po));
            chk("po_valid", i, 32'(bus.po_valid), 32'(vecs[i].e_pv));
            chk("busy",     i, 32'(bus.busy),     32'(vecs[i].e_busy));
            chk("bit_cnt",  i, 32'(bus.bit_cnt),  32'(vecs[i].e_cnt));
            chk("overrun",  i, 32'(bus.overrun),  32'(vecs[i].e_ovr));
        end

        // Back-to-back frames at the minimum period with po_ready held high:
        // each word must appear for exactly one cycle, in order, no overrun.
        exp_w[0] = 4'hA; exp_w[1] = 4'h5; exp_w[2] = 4'hE;
        mon = 1'b1;
        for (int f = 0; f < 3; f++) frame(exp_w[f]);
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) tick();
        mon = 1'b0;
        chk("b2b_count", 0, 32'(words.size()), 32'd3);
        for (int f = 0; f < 3; f++) begin
            if (f < words.size()) chk("b2b_word", f, 32'(words[f]), 32'(exp_w[f]));
            else chk("b2b_word_missing", f, 32'hFFFF_FFFF, 32'(exp_w[f]));
        end
        chk("b2b_overrun", 0, 32'(bus.overrun), 32'd0);
        chk("b2b_busy",    0, 32'(bus.busy),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
